pattern_mem_db: RTL and testbench

Double-buffered, multi-channel, serially programmed pattern memory for the PWM pattern engine. A framed bit stream selects a channel and loads a full pattern into that channel's shadow bank. An even-parity check guards the load, and the new pattern goes live only at the next pattern-period boundary. The PWM generators keep reading a stable active bank throughout, with glitch-free reprogramming per channel.

---
 rtl/ppwm_pkg.sv | 17 +
 rtl/pattern_bank.sv | 37 +++
 rtl/pattern_mem_db.sv | 168 ++++++++++++++++
 tb/tb_pattern_mem_db.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppwm_pkg.sv
// Shared types and helpers for the PWM pattern engine memory.
package ppwm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StShift,
    StParity,
    StPending
  } state_e;

  // Width of a channel field; a single channel still needs one header bit.
  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/pattern_bank.sv
// One pattern bank: an N-bit right-shifting register with a word-wide read port.
module pattern_bank #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 32,
  localparam int N  = WIDTH * DEPTH,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en_i,
  input  logic             sin_i,
  input  logic [AW-1:0]    addr_i,
  output logic [WIDTH-1:0] word_o
);

  logic [N-1:0]     bits_q;
  logic [N-1:0]     bits_d;
  logic [WIDTH-1:0] words [DEPTH];

  // New bits enter at the top so the first bit shifted in ends at word 0 bit 0.
  always_comb begin
    bits_d = shift_en_i ? {sin_i, bits_q[N-1:1]} : bits_q;
  end

  // Bank storage, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bits_q <= '0;
    else     bits_q <= bits_d;
  end

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    assign words[w] = bits_q[w*WIDTH +: WIDTH];
  end

  assign word_o = words[addr_i];

endmodule

// File: rtl/pattern_mem_db.sv
// Double-buffered multi-channel pattern memory, loaded by a framed serial stream
// and committed per channel at a pattern-period boundary.
module pattern_mem_db
  import ppwm_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int DEPTH    = 32,
  parameter int CHANNELS = 2,
  localparam int CH_W  = ch_width(CHANNELS),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int N     = WIDTH * DEPTH,
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_i,
  input  logic                frame_i,
  input  logic [CH_W-1:0]     ch_i,
  input  logic [AW-1:0]       addr_i,
  output logic [WIDTH-1:0]    data_o,
  output logic [CHANNELS-1:0] programmed_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(CH_W - 1);
  localparam logic [CNT_W-1:0] N_LAST   = CNT_W'(N - 1);
  localparam logic [CH_W:0]    CH_LIM   = (CH_W + 1)'(CHANNELS);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                par_q, par_d;
  logic                err_q, err_d;
  logic [CHANNELS-1:0] sel_q, sel_d;
  logic [CHANNELS-1:0] prog_q, prog_d;

  logic [CH_W:0]       hdr_shift;
  logic                ch_ok;
  logic [CHANNELS-1:0] sh0, sh1;
  logic [WIDTH-1:0]    rd0 [CHANNELS];
  logic [WIDTH-1:0]    rd1 [CHANNELS];

  // Header bits arrive LSB first, so each new bit enters at the channel MSB.
  assign hdr_shift = {data_i, ch_q};
  assign ch_ok     = ({1'b0, ch_q} < CH_LIM);

  // State register and frame-reception bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ch_q    <= '0;
      par_q   <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      prog_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      par_q   <= par_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      prog_q  <= prog_d;
    end
  end

  // Next-state logic: frame parsing, parity check and swap on frame_i.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    par_d   = par_q;
    err_d   = err_q;
    sel_d   = sel_q;
    prog_d  = prog_q;
    case (state_q)
      StIdle: begin
        if (data_i) begin
          cnt_d   = '0;
          par_d   = 1'b0;
          err_d   = 1'b0;
          state_d = StHeader;
        end
      end
      StHeader: begin
        ch_d  = hdr_shift[CH_W:1];
        par_d = par_q ^ data_i;
        if (cnt_q == HDR_LAST) begin
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StShift: begin
        par_d = par_q ^ data_i;
        if (cnt_q == N_LAST) state_d = StParity;
        else                 cnt_d   = cnt_q + CNT_W'(1);
      end
      StParity: begin
        if ((data_i == par_q) && ch_ok) begin
          state_d = StPending;
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StPending: begin
        if (frame_i) begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (ch_q == CH_W'(c)) begin
              sel_d[c]  = ~sel_q[c];
              prog_d[c] = 1'b1;
            end
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs and bank shift enables; only the inactive bank of the latched channel shifts.
  always_comb begin
    busy_o = (state_q != StIdle);
    sh0    = '0;
    sh1    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if ((state_q == StShift) && (ch_q == CH_W'(c))) begin
        sh0[c] = sel_q[c];
        sh1[c] = ~sel_q[c];
      end
    end
  end

  assign err_o        = err_q;
  assign programmed_o = prog_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pattern_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank0 (
      .clk       (clk),
      .rst       (rst),
      .shift_en_i(sh0[c]),
      .sin_i     (data_i),
      .addr_i    (addr_i),
      .word_o    (rd0[c])
    );
    pattern_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank1 (
      .clk       (clk),
      .rst       (rst),
      .shift_en_i(sh1[c]),
      .sin_i     (data_i),
      .addr_i    (addr_i),
      .word_o    (rd1[c])
    );
  end

  // Read mux: active bank of the selected channel, zero for a nonexistent channel.
  always_comb begin
    data_o = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_i == CH_W'(c)) data_o = sel_q[c] ? rd1[c] : rd0[c];
    end
  end

endmodule

// File: tb/tb_pattern_mem_db.sv
// Self-checking bench for pattern_mem_db: a 2-channel and a 3-channel instance,
// driven with framed serial loads and compared against a pattern-level model.
module tb_pattern_mem_db;

  localparam int N = 192;

  logic       clk = 1'b0;
  logic       rst;
  logic       d0, f0, ch0;
  logic [4:0] a0;
  logic [5:0] q0;
  logic [1:0] p0;
  logic       b0, e0;
  logic       d3, f3;
  logic [1:0] ch3;
  logic [4:0] a3;
  logic [5:0] q3;
  logic [2:0] p3;
  logic       b3, e3;

  always #5 clk = ~clk;

  pattern_mem_db #(.WIDTH(6), .DEPTH(32), .CHANNELS(2)) dut (
    .clk(clk), .rst(rst), .data_i(d0), .frame_i(f0), .ch_i(ch0), .addr_i(a0),
    .data_o(q0), .programmed_o(p0), .busy_o(b0), .err_o(e0)
  );

  pattern_mem_db #(.WIDTH(6), .DEPTH(32), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .data_i(d3), .frame_i(f3), .ch_i(ch3), .addr_i(a3),
    .data_o(q3), .programmed_o(p3), .busy_o(b3), .err_o(e3)
  );

  // Reference model: committed patterns, a pending pattern, flags.
  logic [5:0] act [2][3][32];
  logic [5:0] pend [2][32];
  int         pend_ch [2];
  bit         pend_v [2];
  logic [2:0] prog_m [2];
  bit         err_m [2];
  logic [5:0] pat [32];
  bit         fq [$];
  int         errs = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 3; c++)
        for (int w = 0; w < 32; w++) act[m][c][w] = '0;
      pend_v[m] = 0;
      prog_m[m] = '0;
      err_m[m]  = 0;
    end
  endtask

  task automatic drive(input int m, input bit b);
    if (m == 0) d0 = b; else d3 = b;
  endtask

  task automatic build_frame(input int m, input int ch, input bit flip);
    int chw;
    bit p;
    chw = (m == 0) ? 1 : 2;
    p = 0;
    fq.delete();
    fq.push_back(1'b1);
    for (int i = 0; i < chw; i++) begin
      fq.push_back(((ch >> i) & 1) != 0);
      p ^= (((ch >> i) & 1) != 0);
    end
    for (int j = 0; j < N; j++) begin
      fq.push_back(pat[j / 6][j % 6]);
      p ^= pat[j / 6][j % 6];
    end
    fq.push_back(p ^ flip);
  endtask

  // Sends a whole frame; optionally pulses frame_i during the parity cycle.
  task automatic send_frame(input int m, input int ch, input bit flip, input bit fr_at_par);
    int nch;
    nch = (m == 0) ? 2 : 3;
    build_frame(m, ch, flip);
    for (int i = 0; i < fq.size(); i++) begin
      drive(m, fq[i]);
      if (i == fq.size() - 1 && fr_at_par) begin
        if (m == 0) f0 = 1'b1; else f3 = 1'b1;
      end
      tick();
      if (i == 0) begin
        chk($sformatf("err_clr%0d", m), (m == 0) ? e0 : e3, 0);
        chk($sformatf("busy_start%0d", m), (m == 0) ? b0 : b3, 1);
      end
    end
    drive(m, 1'b0);
    f0 = 1'b0;
    f3 = 1'b0;
    if (!flip && ch < nch) begin
      pend_v[m]  = 1;
      pend_ch[m] = ch;
      for (int w = 0; w < 32; w++) pend[m][w] = pat[w];
      err_m[m] = 0;
    end else begin
      pend_v[m] = 0;
      err_m[m]  = 1;
    end
  endtask

  task automatic pulse(input int m);
    if (m == 0) f0 = 1'b1; else f3 = 1'b1;
    tick();
    f0 = 1'b0;
    f3 = 1'b0;
    if (pend_v[m]) begin
      for (int w = 0; w < 32; w++) act[m][pend_ch[m]][w] = pend[m][w];
      prog_m[m][pend_ch[m]] = 1'b1;
      pend_v[m] = 0;
    end
  endtask

  task automatic rd_chk(input int m, input int c, input int a);
    if (m == 0) begin ch0 = c[0]; a0 = a[4:0]; end
    else        begin ch3 = c[1:0]; a3 = a[4:0]; end
    #1;
    chk($sformatf("data%0d_c%0d_a%0d", m, c, a), (m == 0) ? q0 : q3, act[m][c][a]);
  endtask

  task automatic check_state(input int m);
    int nch;
    nch = (m == 0) ? 2 : 3;
    if (m == 0) begin
      chk("busy0", b0, pend_v[0]);
      chk("err0", e0, err_m[0]);
      chk("prog0", p0, prog_m[0][1:0]);
    end else begin
      chk("busy3", b3, pend_v[1]);
      chk("err3", e3, err_m[1]);
      chk("prog3", p3, prog_m[1]);
    end
    for (int c = 0; c < nch; c++)
      for (int k = 0; k < ((m == 0) ? 3 : 2); k++)
        rd_chk(m, c, $urandom_range(31));
  endtask

  task automatic fill_const(input logic [5:0] v);
    for (int w = 0; w < 32; w++) pat[w] = v;
  endtask

  task automatic fill_rand();
    for (int w = 0; w < 32; w++) pat[w] = 6'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; d0 = 0; f0 = 0; ch0 = 0; a0 = 0; d3 = 0; f3 = 0; ch3 = 0; a3 = 0;
    model_reset();
    tick(); tick();
    check_state(0);
    check_state(1);
    rst = 1'b0;
    tick();

    // Program and commit channel 0 with word k = k.
    for (int w = 0; w < 32; w++) pat[w] = 6'(w);
    send_frame(0, 0, 0, 0);
    rd_chk(0, 0, 5);
    chk("busy_pending", b0, 1);
    pulse(0);
    rd_chk(0, 0, 5);
    chk("prog_01", p0, 2'b01);
    chk("busy_idle", b0, 0);
    check_state(0);

    // Double buffering on channel 1.
    fill_const(6'h2A);
    send_frame(0, 1, 0, 0);
    pulse(0);
    check_state(0);
    fill_const(6'h15);
    send_frame(0, 1, 0, 0);
    check_state(0);
    for (int i = 0; i < 5; i++) tick();
    rd_chk(0, 1, 7);
    pulse(0);
    check_state(0);
    rd_chk(0, 1, 7);

    // Parity error, then frame_i is ignored; back-to-back valid frame follows.
    fill_rand();
    send_frame(0, 0, 1, 0);
    check_state(0);
    pulse(0);
    check_state(0);
    fill_rand();
    send_frame(0, 1, 1, 0);
    fill_rand();
    send_frame(0, 1, 0, 0);
    pulse(0);
    check_state(0);

    // frame_i during parity is ignored; back-to-back commits to ch 0 then ch 1.
    fill_rand();
    send_frame(0, 0, 0, 1);
    check_state(0);
    tick();
    check_state(0);
    pulse(0);
    fill_rand();
    send_frame(0, 1, 0, 0);
    pulse(0);
    check_state(0);

    // Randomized traffic on the 2-channel instance.
    for (int it = 0; it < 8; it++) begin
      fill_rand();
      send_frame(0, $urandom_range(1), ($urandom_range(3) == 0), $urandom_range(1));
      check_state(0);
      for (int g = $urandom_range(3); g > 0; g--) tick();
      if ($urandom_range(3) != 0) pulse(0);
      check_state(0);
    end

    // Out-of-range channel on the 3-channel instance.
    fill_rand();
    send_frame(1, 2, 0, 0);
    pulse(1);
    fill_rand();
    send_frame(1, 0, 0, 0);
    pulse(1);
    check_state(1);
    fill_rand();
    send_frame(1, 3, 0, 0);
    check_state(1);
    pulse(1);
    check_state(1);
    fill_rand();
    send_frame(1, 1, 0, 0);
    pulse(1);
    check_state(1);

    // Asynchronous reset at payload bit 100.
    fill_rand();
    build_frame(0, 1, 0);
    for (int i = 0; i < 1 + 1 + 100; i++) begin
      drive(0, fq[i]);
      tick();
    end
    #2;
    rst = 1'b1;
    d0 = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", b0, 0);
    chk("rst_err", e0, 0);
    chk("rst_prog", p0, 0);
    chk("rst_prog3", p3, 0);
    rd_chk(0, 0, 5);
    rd_chk(0, 1, 0);
    rd_chk(1, 2, 9);
    rd_chk(1, 0, 31);
    tick();
    rst = 1'b0;
    tick();
    fill_rand();
    send_frame(0, 1, 0, 0);
    pulse(0);
    check_state(0);
    check_state(1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
